// File: rtl/irq_pkg.sv
// Shared defaults and state type for the interrupt request encoder.
package irq_pkg;

    localparam int N_DEF = 6;
    localparam int W_DEF = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

endpackage

// File: rtl/prio_enc.sv
// Fixed-priority encoder: lowest set bit wins, reports whether any bit is set.
module prio_enc #(
    parameter int N = 6,
    parameter int W = 3
) (
    input  logic [N-1:0] vec_i,
    output logic         found_o,
    output logic [W-1:0] idx_o
);

    // Scan from the top so the lowest set index is the last to write.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                found_o = 1'b1;
                idx_o   = W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_encoder.sv
// Sticky request capture with one-at-a-time presentation of the
// highest-priority pending index over a valid/ack handshake.
module irq_encoder
    import irq_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] req_in,
    input  logic         ack,
    output logic [W-1:0] code,
    output logic         valid,
    output logic [N-1:0] pending,
    output logic [W:0]   pend_cnt
);

    state_t         state_q, state_d;
    logic [W-1:0]   code_q, code_d;
    logic [N-1:0]   pend_q, pend_d;
    logic           found;
    logic [W-1:0]   top_idx;
    logic           hs;
    logic [N-1:0]   clr_mask;

    prio_enc #(
        .N (N),
        .W (W)
    ) u_prio (
        .vec_i   (pend_q),
        .found_o (found),
        .idx_o   (top_idx)
    );

    assign hs       = (state_q == PRESENT) && ack;
    assign clr_mask = hs ? (N'(1) << code_q) : '0;
    // New requests are OR'ed in after the clear so a same-edge set wins.
    assign pend_d   = (pend_q & ~clr_mask) | req_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            code_q  <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        unique case (state_q)
            IDLE: begin
                if (en && found) begin
                    state_d = PRESENT;
                    code_d  = top_idx;
                end
            end
            PRESENT: begin
                if (hs || !en) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid = (state_q == PRESENT);
        code  = code_q;
    end

    assign pending = pend_q;

    always_comb begin
        pend_cnt = '0;
        for (int i = 0; i < N; i++) begin
            pend_cnt = pend_cnt + {{W{1'b0}}, pend_q[i]};
        end
    end

endmodule

// File: tb/tb_irq_encoder.sv
// Bench for irq_encoder: directed scenarios plus randomized run vs a model.
module tb_irq_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [5:0] req_in;
    logic       ack;
    logic [2:0] code;
    logic       valid;
    logic [5:0] pending;
    logic [3:0] pend_cnt;

    int checks = 0;
    int passes = 0;

    // Reference model state
    bit [5:0] m_pend;
    bit       m_valid;
    int       m_code;

    irq_encoder #(.N(6), .W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .req_in   (req_in),
        .ack      (ack),
        .code     (code),
        .valid    (valid),
        .pending  (pending),
        .pend_cnt (pend_cnt)
    );

    always #5 clk = ~clk;

    function automatic int count_bits(bit [5:0] v);
        int n = 0;
        for (int i = 0; i < 6; i++) n += v[i];
        return n;
    endfunction

    function automatic int lowest(bit [5:0] v);
        for (int i = 0; i < 6; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_edge();
        bit [5:0] old;
        bit       taken;
        if (rst) begin
            m_pend = '0; m_valid = 0; m_code = 0;
            return;
        end
        old   = m_pend;
        taken = m_valid && ack;
        if (taken) m_pend[m_code] = 0;
        m_pend = m_pend | req_in;
        if (m_valid) begin
            if (taken || !en) m_valid = 0;
        end else if (en && old != 0) begin
            m_valid = 1;
            m_code  = lowest(old);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1; en = 0; req_in = '0; ack = 0;
        m_pend = '0; m_valid = 0; m_code = 0;
        #3;
        checks++; if (valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", valid); else passes++;
        checks++; if (pending !== 6'b0) $display("FAIL reset_pending got %b want 000000", pending); else passes++;
        checks++; if (code !== 3'd0) $display("FAIL reset_code got %0d want 0", code); else passes++;
        checks++; if (pend_cnt !== 4'd0) $display("FAIL reset_cnt got %0d want 0", pend_cnt); else passes++;
        cyc();
        rst = 0;
        cyc();
    endtask

    task automatic test_single();
        en = 1; req_in = 6'b000100;
        cyc();
        req_in = '0;
        checks++; if (pending !== 6'b000100) $display("FAIL single_pend got %b want 000100", pending); else passes++;
        checks++; if (valid !== 1'b0) $display("FAIL single_lat got valid=%0b want 0", valid); else passes++;
        cyc();
        checks++; if (valid !== 1'b1 || code !== 3'd2) $display("FAIL single_present got v=%0b c=%0d want v=1 c=2", valid, code); else passes++;
        checks++; if (pend_cnt !== 4'd1) $display("FAIL single_cnt got %0d want 1", pend_cnt); else passes++;
        ack = 1;
        cyc();
        ack = 0;
        checks++; if (pending !== 6'b0 || valid !== 1'b0) $display("FAIL single_ack got p=%b v=%0b want 000000 0", pending, valid); else passes++;
        cyc();
        checks++; if (valid !== 1'b0) $display("FAIL single_idle got v=%0b want 0", valid); else passes++;
    endtask

    task automatic test_priority_hold();
        req_in = 6'b100000;
        cyc();
        req_in = '0;
        cyc();
        checks++; if (valid !== 1'b1 || code !== 3'd5) $display("FAIL prio_first got v=%0b c=%0d want v=1 c=5", valid, code); else passes++;
        req_in = 6'b000001;
        for (int k = 0; k < 3; k++) begin
            cyc();
            checks++; if (valid !== 1'b1 || code !== 3'd5) $display("FAIL prio_hold%0d got v=%0b c=%0d want v=1 c=5", k, valid, code); else passes++;
        end
        req_in = '0;
        checks++; if (pend_cnt !== 4'd2) $display("FAIL prio_cnt2 got %0d want 2", pend_cnt); else passes++;
        ack = 1;
        cyc();
        ack = 0;
        checks++; if (valid !== 1'b0 || pend_cnt !== 4'd1) $display("FAIL prio_bubble got v=%0b cnt=%0d want v=0 cnt=1", valid, pend_cnt); else passes++;
        cyc();
        checks++; if (valid !== 1'b1 || code !== 3'd0) $display("FAIL prio_next got v=%0b c=%0d want v=1 c=0", valid, code); else passes++;
        ack = 1;
        cyc();
        ack = 0;
        checks++; if (pending !== 6'b0) $display("FAIL prio_clear got %b want 000000", pending); else passes++;
    endtask

    task automatic test_set_clear();
        req_in = 6'b001000;
        cyc();
        req_in = '0;
        cyc();
        checks++; if (valid !== 1'b1 || code !== 3'd3) $display("FAIL sc_present got v=%0b c=%0d want v=1 c=3", valid, code); else passes++;
        ack = 1; req_in = 6'b001000;
        cyc();
        ack = 0; req_in = '0;
        checks++; if (pending !== 6'b001000 || valid !== 1'b0) $display("FAIL sc_setwins got p=%b v=%0b want 001000 0", pending, valid); else passes++;
        cyc();
        checks++; if (valid !== 1'b1 || code !== 3'd3) $display("FAIL sc_again got v=%0b c=%0d want v=1 c=3", valid, code); else passes++;
        ack = 1;
        cyc();
        ack = 0;
        checks++; if (pending !== 6'b0) $display("FAIL sc_clear got %b want 000000", pending); else passes++;
    endtask

    task automatic test_enable();
        en = 0; req_in = 6'b110000;
        cyc();
        req_in = '0;
        checks++; if (pending !== 6'b110000 || valid !== 1'b0) $display("FAIL en_capture got p=%b v=%0b want 110000 0", pending, valid); else passes++;
        for (int k = 0; k < 3; k++) begin
            cyc();
            checks++; if (valid !== 1'b0) $display("FAIL en_off%0d got v=%0b want 0", k, valid); else passes++;
        end
        en = 1;
        cyc();
        checks++; if (valid !== 1'b1 || code !== 3'd4) $display("FAIL en_on got v=%0b c=%0d want v=1 c=4", valid, code); else passes++;
        en = 0;
        cyc();
        checks++; if (valid !== 1'b0 || pending !== 6'b110000) $display("FAIL en_drop got v=%0b p=%b want 0 110000", valid, pending); else passes++;
        en = 1;
        cyc();
        checks++; if (valid !== 1'b1 || code !== 3'd4) $display("FAIL en_resume got v=%0b c=%0d want v=1 c=4", valid, code); else passes++;
        ack = 1;
        cyc();
        cyc();
        checks++; if (valid !== 1'b1 || code !== 3'd5) $display("FAIL en_second got v=%0b c=%0d want v=1 c=5", valid, code); else passes++;
        cyc();
        ack = 0;
        checks++; if (pending !== 6'b0 || valid !== 1'b0) $display("FAIL en_clear got p=%b v=%0b want 000000 0", pending, valid); else passes++;
    endtask

    task automatic test_drain();
        en = 1; ack = 1; req_in = 6'b111111;
        cyc();
        req_in = '0;
        for (int k = 0; k < 6; k++) begin
            checks++; if (pend_cnt !== 4'(6 - k)) $display("FAIL drain_cnt%0d got %0d want %0d", k, pend_cnt, 6 - k); else passes++;
            cyc();
            checks++; if (valid !== 1'b1 || code !== 3'(k)) $display("FAIL drain_code%0d got v=%0b c=%0d want v=1 c=%0d", k, valid, code, k); else passes++;
            cyc();
        end
        ack = 0;
        checks++; if (pend_cnt !== 4'd0 || valid !== 1'b0) $display("FAIL drain_end got cnt=%0d v=%0b want 0 0", pend_cnt, valid); else passes++;
        cyc();
        checks++; if (valid !== 1'b0) $display("FAIL drain_idle got v=%0b want 0", valid); else passes++;
    endtask

    task automatic test_reset_mid();
        en = 1; req_in = 6'b001010;
        cyc();
        req_in = '0;
        cyc();
        checks++; if (valid !== 1'b1 || code !== 3'd1) $display("FAIL rmid_present got v=%0b c=%0d want v=1 c=1", valid, code); else passes++;
        ack = 1;
        #2 rst = 1;
        m_pend = '0; m_valid = 0; m_code = 0;
        #1;
        checks++; if (valid !== 1'b0 || pending !== 6'b0 || code !== 3'd0 || pend_cnt !== 4'd0)
            $display("FAIL rmid_async got v=%0b p=%b c=%0d cnt=%0d want 0 000000 0 0", valid, pending, code, pend_cnt);
        else passes++;
        req_in = 6'b111111;
        cyc();
        req_in = '0; ack = 0;
        checks++; if (pending !== 6'b0) $display("FAIL rmid_hold got %b want 000000", pending); else passes++;
        rst = 0; req_in = 6'b000010;
        cyc();
        req_in = '0;
        checks++; if (pending !== 6'b000010) $display("FAIL rmid_first got %b want 000010", pending); else passes++;
        cyc();
        ack = 1;
        cyc();
        ack = 0;
        checks++; if (pending !== 6'b0 || valid !== 1'b0) $display("FAIL rmid_clear got p=%b v=%0b want 000000 0", pending, valid); else passes++;
    endtask

    task automatic test_random();
        int bad = 0;
        for (int k = 0; k < 400; k++) begin
            en     = ($urandom_range(0, 7) != 0);
            ack    = $urandom_range(0, 1);
            req_in = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'b0;
            cyc();
            if (bad < 5) begin
                checks++;
                if (valid !== m_valid || pending !== m_pend || pend_cnt !== 4'(count_bits(m_pend))
                    || (m_valid && code !== 3'(m_code))) begin
                    $display("FAIL rand%0d got v=%0b c=%0d p=%b cnt=%0d want v=%0b c=%0d p=%b cnt=%0d",
                             k, valid, code, pending, pend_cnt, m_valid, m_code, m_pend, count_bits(m_pend));
                    bad++;
                end else passes++;
            end
            if (code > 3'd5) begin
                checks++;
                $display("FAIL rand_range%0d got c=%0d want <=5", k, code);
            end
        end
        en = 1; ack = 0; req_in = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority_hold();
        test_set_clear();
        test_enable();
        test_drain();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/irq_encoder.md
IRQ_ENCODER -- requirements
Module: irq_encoder

Interface
REQ-001 Parameter N, default 6, number of request lines; SHALL be 2..8.
REQ-002 Parameter W, default 3, code width; SHALL equal ceil(log2(N)).
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  block enable; low suppresses presentation, not capture.
REQ-006 req_in  input  N  request pulses; bit i high for one or more cycles posts request i.
REQ-007 ack  input  1  consumer accepts the presented code.
REQ-008 code  output  W  binary index of the presented request.
REQ-009 valid  output  1  code holds a pending request.
REQ-010 pending  output  N  sticky pending-request register.
REQ-011 pend_cnt  output  W+1  number of bits set in pending, combinational from the pending register.

Function
REQ-012 pending[i] SHALL set on any edge with req_in[i]=1 and stay set until cleared by an accepted ack for index i.
REQ-013 Priority SHALL be fixed: lowest index wins (index 0 highest).
REQ-014 FSM states SHALL be IDLE and PRESENT; valid=1 exactly in PRESENT.
REQ-015 IDLE -> PRESENT when en=1 and pending!=0; code SHALL load the highest-priority pending index on that edge.
REQ-016 Latency: req_in high at edge t into an empty, idle block SHALL give valid=1 after edge t+1 (2 edges).
REQ-017 In PRESENT with ack=0, code and valid SHALL hold stable, even if a higher-priority request arrives.
REQ-018 In PRESENT with ack=1 (handshake = valid & ack), pending[code] SHALL clear and the FSM SHALL return to IDLE; next valid no earlier than 2 edges after the handshake edge (one bubble cycle).
REQ-019 ack while valid=0 SHALL be ignored.
REQ-020 Simultaneous req_in[i]=1 and handshake clearing bit i: set SHALL win; bit i stays pending.
REQ-021 en=0 in PRESENT SHALL return the FSM to IDLE at the next edge, drop valid, and leave pending unchanged; ack in that same cycle is still honoured.
REQ-022 With en=0, req_in SHALL still be captured into pending.
REQ-023 code SHALL hold its last value in IDLE; consumers qualify it with valid only.
REQ-024 Request lines at index >= N do not exist; code SHALL never exceed N-1.

Reset
REQ-025 rst=1 SHALL immediately force state=IDLE, pending=0, code=0, valid=0, pend_cnt=0, regardless of clk.
REQ-026 rst asserted mid-handshake SHALL discard all pending requests; no request captured during rst SHALL survive.
REQ-027 First capture after rst deassertion SHALL occur on the first rising edge with rst=0.

Structure
REQ-028 Shared package irq_pkg SHALL hold N/W defaults and the two-value state enum (IDLE, PRESENT).
REQ-029 One combinational sub-module prio_enc SHALL map an N-bit vector to {found, W-bit lowest-set index}; irq_encoder SHALL instantiate it on pending.
REQ-030 No other sub-modules; pend_cnt computed in irq_encoder.

Verification
REQ-031 Reset: rst pulse mid-PRESENT with pending=6'b001010 -> valid=0, pending=0, code=0 immediately, before next edge.
REQ-032 Single request: req_in=6'b000100 one cycle -> pending=000100 at edge 1, valid=1 code=2 after edge 2; ack -> pending=0, valid=0.
REQ-033 Priority and hold: pending=6'b100000 presented (code=5), then req_in=000001 with ack=0 for 3 cycles -> code stays 5; after ack, code=0 presented 2 edges later, pend_cnt 2->1.
REQ-034 Simultaneous set/clear: presenting code=3, ack=1 with req_in=001000 -> pending[3] stays 1, code=3 re-presented after bubble.
REQ-035 Enable: en=0 with req_in=6'b110000 -> pending=110000, valid=0 throughout; en=1 -> code=4 after next edge.
REQ-036 Drain all: req_in=6'b111111 once, ack held 1 -> codes 0,1,2,3,4,5 in order, each 2 edges apart, pend_cnt 6 down to 0, then valid=0.
